// File: rtl/midi_pkg.sv
// Shared MIDI constants, encoder state type and status-byte helper used by the
// note transmitter and the matching receiver/decoder.
package midi_pkg;

    // 100 MHz system clock divided down to the 31250 baud MIDI rate.
    localparam int CLK_CYCLES_PER_UART_BIT = 3200;

    // Bits per UART frame: start + 8 data + stop.
    localparam int UART_FRAME_BITS = 10;

    // Status-byte high nibbles.
    localparam logic [3:0] MIDI_NOTE_ON  = 4'h9;
    localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;

    // 88-key piano range (A0..C8), shared with the decoder.
    localparam logic [6:0] MIDI_KEY_LOW   = 7'd21;
    localparam logic [6:0] MIDI_KEY_HIGH  = 7'd108;
    localparam int         MIDI_KEY_COUNT = 88;

    // Encoder FSM states.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND_STATUS,
        ST_SEND_NOTE,
        ST_SEND_VEL
    } enc_state_e;

    // Build the Note On / Note Off status byte for a channel.
    function automatic logic [7:0] midi_status(input logic on, input logic [3:0] ch);
        return {(on ? MIDI_NOTE_ON : MIDI_NOTE_OFF), ch};
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. A new byte may be loaded in the same cycle that done
// pulses, so consecutive frames chain with no idle cycle between them.
module uart_tx_byte #(
    parameter int CLK_CYCLES_PER_UART_BIT = midi_pkg::CLK_CYCLES_PER_UART_BIT
) (
    input  logic       clk_100mhz,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready,
    output logic       done
);
    import midi_pkg::*;

    localparam logic [11:0] BIT_LAST  = 12'(CLK_CYCLES_PER_UART_BIT - 1);
    localparam logic [3:0]  IDX_STOP  = 4'(UART_FRAME_BITS - 1);
    localparam logic [3:0]  IDX_LASTD = 4'(UART_FRAME_BITS - 2);

    logic        active_q, active_d;
    logic [11:0] cnt_q, cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  data_q, data_d;
    logic        tx_q, tx_d;

    // Bit timing and shift sequencing; the line value is registered so the
    // output is glitch-free and the start bit appears the cycle after load.
    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        data_d   = data_q;
        tx_d     = tx_q;
        done     = active_q && (idx_q == IDX_STOP) && (cnt_q == BIT_LAST);
        ready    = !active_q;

        if (load && (!active_q || done)) begin
            active_d = 1'b1;
            cnt_d    = 12'd0;
            idx_d    = 4'd0;
            data_d   = data;
            tx_d     = 1'b0;
        end else if (active_q) begin
            if (cnt_q == BIT_LAST) begin
                cnt_d = 12'd0;
                if (idx_q == IDX_STOP) begin
                    active_d = 1'b0;
                    tx_d     = 1'b1;
                end else begin
                    idx_d = idx_q + 4'd1;
                    // Leaving bit idx_q means the line now carries bit idx_q+1:
                    // data bit idx_q for the data positions, then the stop bit.
                    tx_d  = (idx_q == IDX_LASTD) ? 1'b1 : data_q[idx_q[2:0]];
                end
            end else begin
                cnt_d = cnt_q + 12'd1;
            end
        end
    end

    // Serializer state register; reset abandons any partial frame.
    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            active_q <= 1'b0;
            cnt_q    <= 12'd0;
            idx_q    <= 4'd0;
            data_q   <= 8'h00;
            tx_q     <= 1'b1;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            tx_q     <= tx_d;
        end
    end

    assign tx = tx_q;

endmodule

// File: rtl/midi_note_tx.sv
// MIDI Note On/Off transmitter: accepts one event per handshake, encodes it as
// a 3-byte Note message (status optionally elided by running status) and
// streams the bytes back-to-back through the 8N1 serializer.
module midi_note_tx #(
    parameter int CLK_CYCLES_PER_UART_BIT = midi_pkg::CLK_CYCLES_PER_UART_BIT,
    parameter bit RUNNING_STATUS          = 1'b1
) (
    input  logic       clk_100mhz,
    input  logic       reset,
    input  logic       note_valid,
    output logic       note_ready,
    input  logic       note_on,
    input  logic [3:0] channel,
    input  logic [6:0] note,
    input  logic [6:0] velocity,
    output logic       uart_tx,
    output logic       busy,
    output logic       msg_done
);
    import midi_pkg::*;

    enc_state_e  state_q, state_d;
    logic [7:0]  last_status_q, last_status_d;
    logic [6:0]  note_q, note_d;
    logic [6:0]  vel_q, vel_d;

    logic        ser_load;
    logic [7:0]  ser_data;
    logic        ser_tx;
    logic        ser_ready;
    logic        ser_done;
    logic [7:0]  status_new;
    logic        need_status;

    assign status_new  = midi_status(note_on, channel);
    // last_status resets to 0x00, which is never a valid status, so the first
    // message after reset always carries its status byte.
    assign need_status = !RUNNING_STATUS || (status_new != last_status_q);

    // Encoder next-state: the first byte is loaded straight from the inputs in
    // the acceptance cycle, later bytes are loaded on the serializer's done.
    always_comb begin
        state_d       = state_q;
        last_status_d = last_status_q;
        note_d        = note_q;
        vel_d         = vel_q;
        ser_load      = 1'b0;
        ser_data      = 8'h00;
        msg_done      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (note_valid && !reset && ser_ready) begin
                    note_d   = note;
                    vel_d    = velocity;
                    ser_load = 1'b1;
                    if (need_status) begin
                        ser_data      = status_new;
                        last_status_d = status_new;
                        state_d       = ST_SEND_STATUS;
                    end else begin
                        ser_data = {1'b0, note};
                        state_d  = ST_SEND_NOTE;
                    end
                end
            end
            ST_SEND_STATUS: begin
                if (ser_done) begin
                    ser_load = 1'b1;
                    ser_data = {1'b0, note_q};
                    state_d  = ST_SEND_NOTE;
                end
            end
            ST_SEND_NOTE: begin
                if (ser_done) begin
                    ser_load = 1'b1;
                    ser_data = {1'b0, vel_q};
                    state_d  = ST_SEND_VEL;
                end
            end
            ST_SEND_VEL: begin
                if (ser_done) begin
                    msg_done = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Encoder state, running-status memory and latched event fields.
    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            last_status_q <= 8'h00;
            note_q        <= 7'd0;
            vel_q         <= 7'd0;
        end else begin
            state_q       <= state_d;
            last_status_q <= last_status_d;
            note_q        <= note_d;
            vel_q         <= vel_d;
        end
    end

    assign note_ready = (state_q == ST_IDLE);
    assign busy       = !note_ready;
    assign uart_tx    = ser_tx;

    uart_tx_byte #(
        .CLK_CYCLES_PER_UART_BIT(CLK_CYCLES_PER_UART_BIT)
    ) u_ser (
        .clk_100mhz(clk_100mhz),
        .reset     (reset),
        .load      (ser_load),
        .data      (ser_data),
        .tx        (ser_tx),
        .ready     (ser_ready),
        .done      (ser_done)
    );

endmodule

// File: tb/tb_midi_note_tx.sv
// Bench for midi_note_tx: a cycle-level behavioural model predicts the line
// waveform, ready/busy and msg_done from message start times and byte lists;
// a UART receiver decodes the line at mid-bit and checks stop bits and bytes.
module tb_midi_note_tx;

    localparam int BIT = 16;
    localparam int F   = 10 * BIT;
    localparam int TMO = 4 * F;

    logic       clk_100mhz = 1'b0;
    logic       reset      = 1'b1;
    logic       note_valid = 1'b0;
    logic       note_on    = 1'b0;
    logic [3:0] channel    = 4'd0;
    logic [6:0] note       = 7'd0;
    logic [6:0] velocity   = 7'd0;
    int         sel        = 0;

    logic v0, v1;
    logic rdy0, tx0, busy0, done0;
    logic rdy1, tx1, busy1, done1;
    logic cur_tx, cur_ready, cur_busy, cur_done;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit checking = 1'b0;

    // behavioural model state
    bit         m_active = 1'b0;
    int         m_start  = 0;
    int         m_n      = 0;
    logic [7:0] m_bytes [3];
    logic [7:0] m_last   = 8'h00;
    int         m_acc    = 0;
    bit         m_idle_v = 1'b1;
    int         start_q[$];
    int         done_q[$];
    logic [7:0] rx_log[$];

    // receiver model state
    bit         rx_busy = 1'b0;
    int         rx_cnt  = 0;
    int         rx_fs   = 0;
    logic [7:0] rx_sh   = 8'h00;

    always #5 clk_100mhz = ~clk_100mhz;

    assign v0 = note_valid && (sel == 0);
    assign v1 = note_valid && (sel == 1);

    midi_note_tx #(.CLK_CYCLES_PER_UART_BIT(BIT), .RUNNING_STATUS(1'b1)) dut_rs (
        .clk_100mhz(clk_100mhz), .reset(reset), .note_valid(v0), .note_ready(rdy0),
        .note_on(note_on), .channel(channel), .note(note), .velocity(velocity),
        .uart_tx(tx0), .busy(busy0), .msg_done(done0));

    midi_note_tx #(.CLK_CYCLES_PER_UART_BIT(BIT), .RUNNING_STATUS(1'b0)) dut_nr (
        .clk_100mhz(clk_100mhz), .reset(reset), .note_valid(v1), .note_ready(rdy1),
        .note_on(note_on), .channel(channel), .note(note), .velocity(velocity),
        .uart_tx(tx1), .busy(busy1), .msg_done(done1));

    assign cur_tx    = (sel == 1) ? tx1   : tx0;
    assign cur_ready = (sel == 1) ? rdy1  : rdy0;
    assign cur_busy  = (sel == 1) ? busy1 : busy0;
    assign cur_done  = (sel == 1) ? done1 : done0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    always @(posedge clk_100mhz) cyc <= cyc + 1;

    // Per-cycle compare, receiver decode and model prediction for next edge.
    always @(negedge clk_100mhz) begin
        int c, endc, off, b, bi, k;
        logic exp_tx, exp_rdy, exp_done;
        logic [7:0] st;
        c        = cyc;
        endc     = m_start + m_n * F;
        exp_rdy  = !m_active || (c >= endc);
        exp_done = m_active && (c == endc - 1);
        exp_tx   = 1'b1;
        if (m_active && c >= m_start && c < endc) begin
            off = c - m_start;
            b   = off / F;
            bi  = (off % F) / BIT;
            exp_tx = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : m_bytes[b][bi-1];
        end
        if (checking) begin
            chk("uart_tx", 32'(cur_tx), 32'(exp_tx));
            chk("note_ready", 32'(cur_ready), 32'(exp_rdy));
            chk("busy", 32'(cur_busy), 32'(!exp_rdy));
            chk("msg_done", 32'(cur_done), 32'(exp_done));
            if (cur_done) done_q.push_back(c);

            if (reset) begin
                rx_busy = 1'b0;
            end else begin
                if (!rx_busy && cur_tx == 1'b0) begin
                    rx_busy = 1'b1;
                    rx_cnt  = 0;
                    rx_fs   = c;
                end
                if (rx_busy) begin
                    if (rx_cnt % BIT == BIT / 2) begin
                        k = rx_cnt / BIT;
                        if (k == 0) chk("rx_start_bit", 32'(cur_tx), 32'd0);
                        else if (k <= 8) rx_sh[k-1] = cur_tx;
                        else begin
                            chk("rx_stop_bit", 32'(cur_tx), 32'd1);
                            b = (rx_fs - m_start) / F;
                            if (b >= 0 && b < m_n) chk("rx_byte", 32'(rx_sh), 32'(m_bytes[b]));
                            else chk("rx_frame_in_msg", 32'(b), 32'(m_n));
                            rx_log.push_back(rx_sh);
                            rx_busy = 1'b0;
                        end
                    end
                    rx_cnt++;
                end
            end

            if (reset) begin
                m_active = 1'b0;
                m_last   = 8'h00;
            end else if (note_valid && exp_rdy) begin
                st = {(note_on ? 4'h9 : 4'h8), channel};
                if (sel == 1 || st != m_last) begin
                    m_bytes[0] = st;
                    m_bytes[1] = {1'b0, note};
                    m_bytes[2] = {1'b0, velocity};
                    m_n    = 3;
                    m_last = st;
                end else begin
                    m_bytes[0] = {1'b0, note};
                    m_bytes[1] = {1'b0, velocity};
                    m_n = 2;
                end
                m_start  = c + 1;
                m_active = 1'b1;
                m_acc++;
                start_q.push_back(c + 1);
            end
            m_idle_v = !m_active || (c + 1 >= m_start + m_n * F);
        end
    end

    task automatic send_ev(input logic on, input logic [3:0] ch, input logic [6:0] n, input logic [6:0] v);
        int t;
        t = 0;
        while (!cur_ready && t < TMO) begin
            @(posedge clk_100mhz); #1;
            t++;
        end
        if (!cur_ready) chk("send_wait_ready", 32'(cur_ready), 32'd1);
        note_on = on; channel = ch; note = n; velocity = v;
        note_valid = 1'b1;
        @(posedge clk_100mhz); #1;
        note_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        do begin
            @(posedge clk_100mhz); #1;
            t++;
        end while (!(m_idle_v && cur_ready) && t < TMO);
        if (t >= TMO) chk("wait_idle_timeout", 32'(t), 32'(TMO - 1));
        repeat (2) begin @(posedge clk_100mhz); #1; end
    endtask

    task automatic check_log(input string nm, input int n, input logic [7:0] w [6]);
        chk({nm, "_count"}, 32'(rx_log.size()), 32'(n));
        for (int i = 0; i < n; i++)
            if (i < rx_log.size()) chk(nm, 32'(rx_log[i]), 32'(w[i]));
        $display("scenario %s: %0d bytes decoded", nm, rx_log.size());
    endtask

    task automatic pulse_reset(input int new_sel);
        reset = 1'b1;
        sel   = new_sel;
        @(posedge clk_100mhz); #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] w [6];
        int t;
        repeat (3) @(posedge clk_100mhz);
        #1;
        reset    = 1'b0;
        checking = 1'b1;

        chk("reset_tx", 32'(cur_tx), 32'd1);
        chk("reset_ready", 32'(cur_ready), 32'd1);
        chk("reset_busy", 32'(cur_busy), 32'd0);
        chk("reset_msg_done", 32'(cur_done), 32'd0);

        // Note On ch0 60/100: full message, 3 frames long.
        rx_log.delete(); start_q.delete(); done_q.delete();
        send_ev(1'b1, 4'd0, 7'd60, 7'd100);
        wait_idle();
        w = '{8'h90, 8'h3C, 8'h64, 8'h00, 8'h00, 8'h00};
        check_log("note_on_ch0", 3, w);
        chk("len3_done_offset", 32'(done_q[0] - start_q[0]), 32'(3 * F - 1));

        // Same event again: running status drops the status byte.
        rx_log.delete(); start_q.delete(); done_q.delete();
        send_ev(1'b1, 4'd0, 7'd60, 7'd100);
        wait_idle();
        w = '{8'h3C, 8'h64, 8'h00, 8'h00, 8'h00, 8'h00};
        check_log("running_status", 2, w);
        chk("len2_done_offset", 32'(done_q[0] - start_q[0]), 32'(2 * F - 1));

        // Note Off ch3 after a ch0 Note On: new status must be sent.
        rx_log.delete();
        send_ev(1'b0, 4'd3, 7'd21, 7'd64);
        wait_idle();
        w = '{8'h83, 8'h15, 8'h40, 8'h00, 8'h00, 8'h00};
        check_log("note_off_ch3", 3, w);

        // note_valid held across a whole message: exactly two acceptances.
        rx_log.delete(); start_q.delete(); done_q.delete();
        t = m_acc;
        note_on = 1'b1; channel = 4'd1; note = 7'd70; velocity = 7'd10;
        note_valid = 1'b1;
        @(posedge clk_100mhz); #1;
        note = 7'd72; velocity = 7'd20;
        begin
            int g;
            g = 0;
            while (!cur_ready && g < TMO) begin @(posedge clk_100mhz); #1; g++; end
        end
        @(posedge clk_100mhz); #1;
        note_valid = 1'b0;
        wait_idle();
        w = '{8'h91, 8'h46, 8'h0A, 8'h48, 8'h14, 8'h00};
        check_log("held_valid", 5, w);
        chk("held_accept_count", 32'(m_acc - t), 32'd2);
        chk("held_first_len", 32'(done_q[0] - start_q[0]), 32'(3 * F - 1));
        chk("held_gap", 32'(start_q[1] - done_q[0]), 32'd2);

        // Reset in the middle of byte 2, then the same Note On re-sends 0x90.
        rx_log.delete(); start_q.delete();
        send_ev(1'b1, 4'd0, 7'd60, 7'd100);
        t = 0;
        while (cyc < start_q[0] + F + F / 2 && t < TMO) begin @(posedge clk_100mhz); #1; t++; end
        pulse_reset(0);
        chk("midreset_tx", 32'(cur_tx), 32'd1);
        chk("midreset_busy", 32'(cur_busy), 32'd0);
        rx_log.delete();
        send_ev(1'b1, 4'd0, 7'd60, 7'd100);
        wait_idle();
        w = '{8'h90, 8'h3C, 8'h64, 8'h00, 8'h00, 8'h00};
        check_log("after_reset", 3, w);

        // RUNNING_STATUS=0 instance: two identical events, both fully sent.
        pulse_reset(1);
        rx_log.delete();
        send_ev(1'b1, 4'd0, 7'd60, 7'd100);
        send_ev(1'b1, 4'd0, 7'd60, 7'd100);
        wait_idle();
        w = '{8'h90, 8'h3C, 8'h64, 8'h90, 8'h3C, 8'h64};
        check_log("no_running_status", 6, w);

        // Randomized events on the running-status instance.
        pulse_reset(0);
        for (int i = 0; i < 24; i++) begin
            send_ev(1'($urandom_range(0, 1)), 4'($urandom_range(0, 1)),
                    7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)));
            $display("random event %0d accepted at cycle %0d, %0d bytes", i, m_start, m_n);
            repeat ($urandom_range(0, 5)) @(posedge clk_100mhz);
            #1;
        end
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
